// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master, one DATA_WIDTH frame per start, MSB first.
// Optional build macro SPI_CONTROLLER_LOOPBACK_EN routes internal mosi into the receive register.
`default_nettype none

module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  ss,
  input  logic                  miso
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t                state;
  logic [7:0]            div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_next;
  logic                  rx_bit;

  assign tx_next = tx_shift << 1;

`ifdef SPI_CONTROLLER_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = miso;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[DATA_WIDTH-1];
            ss       <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= LEAD;
          end
        end
        LEAD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], rx_bit};
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            tx_shift <= tx_next;
            mosi     <= tx_next[DATA_WIDTH-1];
            state    <= LOW;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            // Final LOW is the trailing half-period before ss is released.
            if (bit_cnt == BIT_LAST) begin
              ss      <= 1'b1;
              mosi    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_shift;
              state   <= GAP;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], rx_bit};
              state    <= HIGH;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ss    <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized frames checked cycle by cycle against a timeline model of the SPI master.
`default_nettype none

module tb_spi_controller;

  localparam int DW  = 8;
  localparam int DIV = 4;
  localparam int FRAME_LEN = (2 * DW + 1) * DIV;
  localparam int DONE_C    = FRAME_LEN + 1;
  localparam int END_C     = (2 * DW + 2) * DIV + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          busy, done, sclk, mosi, ss;
  logic [DW-1:0] rx_data;
  logic          miso = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_rx = '0;

  spi_controller #(.CLK_DIV(DIV), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ss"}, 32'(ss), 32'd1);
    check({tag, "_sclk"}, 32'(sclk), 32'd0);
    check({tag, "_mosi"}, 32'(mosi), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle("idle");
      miso = 1'(($urandom));
    end
  endtask

  // Runs one frame from a negedge with the DUT idle; ends at the negedge where busy is low again.
  // abort_at > 0 asserts reset at that cycle and checks the aborted state the cycle after.
  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] pat,
                           input logic [DW-1:0] chg, input bit hold, input int abort_at);
    logic [DW-1:0] rx_frame;
    int p, j, k;
`ifdef SPI_CONTROLLER_LOOPBACK_EN
    rx_frame = tx;
`else
    rx_frame = pat;
`endif
    start   = 1'b1;
    tx_data = tx;
    miso    = 1'(($urandom));
    for (int c = 1; c <= END_C; c++) begin
      @(negedge clk);
      if (abort_at > 0 && c == abort_at + 1) begin
        exp_rx = '0;
        check_idle("abort");
        return;
      end
      p = c - 1 - DIV;
      check("ss", 32'(ss), (c <= FRAME_LEN) ? 32'd0 : 32'd1);
      check("sclk", 32'(sclk),
            (p >= 0 && p < 2 * DW * DIV && (p % (2 * DIV)) < DIV) ? 32'd1 : 32'd0);
      check("busy", 32'(busy), (c < END_C) ? 32'd1 : 32'd0);
      check("done", 32'(done), (c == DONE_C) ? 32'd1 : 32'd0);
      j = (c - 1) / (2 * DIV);
      if (c > FRAME_LEN) check("mosi_idle", 32'(mosi), 32'd0);
      else if (j < DW) check("mosi", 32'(mosi), 32'(tx[DW-1-j]));
      if (c == DONE_C) exp_rx = rx_frame;
      check("rx", 32'(rx_data), 32'(exp_rx));
      start = hold;
      if (c == 10) tx_data = chg;
      if (abort_at > 0 && c == abort_at) rst_n = 1'b0;
      // Peripheral presents bit k ahead of the k-th rising sclk; other cycles carry noise.
      k = (c - DIV) / (2 * DIV);
      if (c >= DIV && ((c - DIV) % (2 * DIV)) == 0 && k < DW) miso = pat[DW-1-k];
      else miso = 1'(($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    idle(2);

    run_frame(8'hA5, 8'h3C, 8'h5A, 1'b0, 0);
    idle(1);
    run_frame(8'h00, 8'hFF, 8'hFF, 1'b0, 0);

    for (int n = 0; n < 8; n++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
      idle(int'($urandom_range(0, 3)));
    end

    // Back-to-back frames with start held continuously.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
    @(negedge clk);
    start = 1'b0;
    check("hold_restart_ss", 32'(ss), 32'd0);
    check("hold_restart_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    exp_rx = '0;
    check_idle("hold_reset");
    rst_n = 1'b1;
    idle(1);

    // Seed rx_data, then abort a frame and confirm it is cleared with no done pulse.
    run_frame(8'h81, 8'hC3, 8'h00, 1'b0, 0);
    run_frame(8'h5A, 8'h96, 8'h11, 1'b0, 30);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("start_in_reset");
    end
    rst_n = 1'b1;
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per frame.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: request one frame; accepted only when busy=0.
REQ-006 SHALL have port tx_data, input, DATA_WIDTH: frame to send, MSB first.
REQ-007 SHALL have port busy, output, 1: high from the cycle after acceptance until return to IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-009 SHALL have port rx_data, output, DATA_WIDTH: last received frame.
REQ-010 SHALL have port sclk, output, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port mosi, output, 1: serial data to the peripheral.
REQ-012 SHALL have port ss, output, 1: slave select, active-low.
REQ-013 SHALL have port miso, input, 1: serial data from the peripheral.

Function
REQ-014 SHALL implement states IDLE, LEAD, HIGH, LOW, GAP.
REQ-015 In IDLE with start=1, SHALL capture tx_data into the shift register and enter LEAD; next cycle ss=0, busy=1, mosi=tx_data[MSB].
REQ-016 LEAD SHALL last CLK_DIV cycles with sclk=0, then enter HIGH.
REQ-017 On entry to HIGH, SHALL drive sclk=1 and shift miso into the receive register LSB in the same edge; HIGH lasts CLK_DIV cycles.
REQ-018 LOW SHALL drive sclk=0 for CLK_DIV cycles and present the next bit on mosi at its first cycle; after the last bit, LOW is the trailing half-period.
REQ-019 SHALL count bits 0..DATA_WIDTH-1; after HIGH of bit DATA_WIDTH-1 and its LOW, SHALL enter GAP.
REQ-020 Frame length: ss SHALL be low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles.
REQ-021 On GAP entry, SHALL set ss=1, sclk=0, update rx_data, and pulse done=1 for that cycle only.
REQ-022 GAP SHALL hold busy=1 for CLK_DIV cycles (minimum ss-high time), then return to IDLE with busy=0.
REQ-023 start while busy=1, including in the done cycle, SHALL be ignored without queueing.
REQ-024 tx_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-025 mosi SHALL be 0 whenever ss=1.
REQ-026 rx_data SHALL hold its value until the next done.

Reset
REQ-027 With rst_n=0 at a clk edge: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, counters=0.
REQ-028 Reset mid-frame SHALL abort with no done pulse, and rx_data SHALL be cleared.
REQ-029 A start held during reset SHALL NOT begin a frame until the first edge with rst_n=1.

Configuration
REQ-030 Macro SPI_CONTROLLER_LOOPBACK_EN: when defined, the receive register SHALL sample the internal mosi instead of the miso port, so rx_data=tx_data after each frame; ss, sclk, and mosi are unchanged.
REQ-031 When SPI_CONTROLLER_LOOPBACK_EN is undefined, the receive register SHALL sample miso, and no loopback logic SHALL be present.

Verification (CLK_DIV=4, DATA_WIDTH=8, start accepted at edge 0)
REQ-032 tx_data=0xA5, miso model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1; ss low from cycle 1 through cycle 68; done at cycle 69; rx_data=0x3C; busy=0 at cycle 73.
REQ-033 Measure sclk -> exactly 8 rising edges per frame, each high 4 cycles; first rise at cycle 5; sclk=0 while ss=1.
REQ-034 start held high continuously -> second frame's ss falls no earlier than 5 cycles after the first frame's ss rises; one done per frame.
REQ-035 rst_n=0 at cycle 30 of a frame -> next cycle ss=1, sclk=0, busy=0, rx_data=0x00; no done pulse.
REQ-036 Build with SPI_CONTROLLER_LOOPBACK_EN, miso tied 0, tx_data=0x5A -> rx_data=0x5A at done.
REQ-037 tx_data changed to 0xFF at cycle 10 of a 0x00 frame -> mosi stays 0 for the whole frame.
